// File: rtl/step_pulse_decoder_if.sv
// Control inputs and status outputs of the step-pulse decoder.
// The master modport is the register/stimulus side; the slave modport is the decoder.
interface step_pulse_decoder_if #(
    parameter int C_STEP_NUMBER_WIDTH = 16,
    parameter int C_SPEED_DATA_WIDTH  = 16
);
    logic                           clk_en;
    logic                           i_drive;
    logic                           i_dir;
    logic                           pos_load;
    logic [C_STEP_NUMBER_WIDTH-1:0] pos_value;
    logic                           err_clr;
    logic [C_STEP_NUMBER_WIDTH-1:0] position;
    logic [C_STEP_NUMBER_WIDTH-1:0] step_count;
    logic                           state;
    logic [C_SPEED_DATA_WIDTH-1:0]  rt_period;
    logic                           period_valid;
    logic                           dir_err;
    logic                           pos_wrap;

    modport master (
        output clk_en, i_drive, i_dir, pos_load, pos_value, err_clr,
        input  position, step_count, state, rt_period, period_valid, dir_err, pos_wrap
    );

    modport slave (
        input  clk_en, i_drive, i_dir, pos_load, pos_value, err_clr,
        output position, step_count, state, rt_period, period_valid, dir_err, pos_wrap
    );
endinterface

// File: rtl/step_pulse_decoder.sv
// Closed-loop monitor for a step/dir motor channel: synchronizes and deglitches drive/dir,
// tracks position and step count, measures the step period and flags direction-setup errors.
module step_pulse_decoder #(
    parameter int C_STEP_NUMBER_WIDTH = 16,
    parameter int C_SPEED_DATA_WIDTH  = 16,
    parameter int C_SYNC_STAGES       = 2,
    parameter int C_FILTER_LEN        = 3,
    parameter int C_DIR_SETUP         = 4
) (
    input  logic                clk,
    input  logic                reset,
    step_pulse_decoder_if.slave bus
);
    localparam int NW = C_STEP_NUMBER_WIDTH;
    localparam int SW = C_SPEED_DATA_WIDTH;
    localparam int FW = $clog2(C_FILTER_LEN + 1);
    localparam int DW = $clog2(C_DIR_SETUP + 1);
    localparam logic [NW-1:0] POS_MAX   = '1;
    localparam logic [SW-1:0] PER_MAX   = '1;
    localparam logic [FW-1:0] FILT_LAST = FW'(C_FILTER_LEN - 1);
    localparam logic [DW-1:0] DIR_OK    = DW'(C_DIR_SETUP);

    typedef enum logic {S_IDLE = 1'b0, S_RUNNING = 1'b1} state_t;

    function automatic logic [SW-1:0] per_sat_inc(input logic [SW-1:0] v, input logic en);
        return (en && (v != PER_MAX)) ? v + 1'b1 : v;
    endfunction

    function automatic logic [NW-1:0] cnt_sat_inc(input logic [NW-1:0] v);
        return (v != POS_MAX) ? v + 1'b1 : v;
    endfunction

    logic [C_SYNC_STAGES-1:0] r_drv_sync, r_dir_sync;
    logic [FW-1:0]            r_drv_fcnt, r_dir_fcnt;
    logic                     r_drv_filt, r_dir_filt, r_drv_prev, r_step;
    logic [DW-1:0]            r_dir_stab;
    logic [SW-1:0]            r_per, r_rt_period;
    logic [NW-1:0]            r_position, r_step_count;
    logic                     r_period_valid, r_dir_err, r_pos_wrap;
    state_t                   r_state, w_state_next;

    logic                     w_drv_s, w_dir_s, w_drv_flip, w_dir_flip, w_viol, w_wrap;
    logic [SW-1:0]            w_per_tick;

    assign w_drv_s    = r_drv_sync[C_SYNC_STAGES-1];
    assign w_dir_s    = r_dir_sync[C_SYNC_STAGES-1];
    assign w_drv_flip = (w_drv_s != r_drv_filt) && (r_drv_fcnt == FILT_LAST);
    assign w_dir_flip = (w_dir_s != r_dir_filt) && (r_dir_fcnt == FILT_LAST);
    assign w_per_tick = per_sat_inc(r_per, bus.clk_en);
    assign w_viol     = r_step && (r_dir_stab < DIR_OK);
    // A step overridden by pos_load never moves the position, so it cannot wrap either.
    assign w_wrap     = r_step && !bus.pos_load &&
                        (r_dir_filt ? (r_position == '0) : (r_position == POS_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drv_sync <= '0;
            r_dir_sync <= '0;
            r_drv_fcnt <= '0;
            r_dir_fcnt <= '0;
            r_drv_filt <= 1'b0;
            r_dir_filt <= 1'b0;
            r_drv_prev <= 1'b0;
            r_step     <= 1'b0;
            r_dir_stab <= '0;
        end else begin
            r_drv_sync <= {r_drv_sync[C_SYNC_STAGES-2:0], bus.i_drive};
            r_dir_sync <= {r_dir_sync[C_SYNC_STAGES-2:0], bus.i_dir};

            if (w_drv_s == r_drv_filt) begin
                r_drv_fcnt <= '0;
            end else if (w_drv_flip) begin
                r_drv_fcnt <= '0;
                r_drv_filt <= w_drv_s;
            end else begin
                r_drv_fcnt <= r_drv_fcnt + 1'b1;
            end

            if (w_dir_s == r_dir_filt) begin
                r_dir_fcnt <= '0;
            end else if (w_dir_flip) begin
                r_dir_fcnt <= '0;
                r_dir_filt <= w_dir_s;
            end else begin
                r_dir_fcnt <= r_dir_fcnt + 1'b1;
            end

            r_drv_prev <= r_drv_filt;
            r_step     <= r_drv_filt & ~r_drv_prev;

            if (w_dir_flip) begin
                r_dir_stab <= '0;
            end else if (r_dir_stab != DIR_OK) begin
                r_dir_stab <= r_dir_stab + 1'b1;
            end
        end
    end

    // Timeout fires on the cycle the period counter lands on all-ones.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (r_step) w_state_next = S_RUNNING;
            S_RUNNING: if (!r_step && (w_per_tick == PER_MAX)) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_per          <= '0;
            r_rt_period    <= '0;
            r_period_valid <= 1'b0;
            r_step_count   <= '0;
            r_position     <= '0;
            r_dir_err      <= 1'b0;
            r_pos_wrap     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_period_valid <= 1'b0;

            if (r_step) begin
                r_per <= '0;
                if (r_state == S_RUNNING) begin
                    r_rt_period    <= w_per_tick;
                    r_period_valid <= 1'b1;
                    r_step_count   <= cnt_sat_inc(r_step_count);
                end else begin
                    r_step_count <= NW'(1);
                end
            end else begin
                r_per <= w_per_tick;
            end

            if (bus.pos_load) begin
                r_position <= bus.pos_value;
            end else if (r_step) begin
                r_position <= r_dir_filt ? r_position - 1'b1 : r_position + 1'b1;
            end

            if (w_viol) begin
                r_dir_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_dir_err <= 1'b0;
            end

            if (w_wrap) begin
                r_pos_wrap <= 1'b1;
            end else if (bus.err_clr) begin
                r_pos_wrap <= 1'b0;
            end
        end
    end

    assign bus.position     = r_position;
    assign bus.step_count   = r_step_count;
    assign bus.state        = (r_state == S_RUNNING);
    assign bus.rt_period    = r_rt_period;
    assign bus.period_valid = r_period_valid;
    assign bus.dir_err      = r_dir_err;
    assign bus.pos_wrap     = r_pos_wrap;
endmodule

// File: tb/tb_step_pulse_decoder.sv
// Bench for step_pulse_decoder: table of step pulses with scoreboarded position/count/period,
// plus hand sequences for glitch filtering, latency, direction setup, load priority and timeout.
module tb_step_pulse_decoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    step_pulse_decoder_if #(.C_STEP_NUMBER_WIDTH(16), .C_SPEED_DATA_WIDTH(16)) bus ();
    step_pulse_decoder_if #(.C_STEP_NUMBER_WIDTH(16), .C_SPEED_DATA_WIDTH(4))  bus4 ();

    step_pulse_decoder #(
        .C_STEP_NUMBER_WIDTH(16), .C_SPEED_DATA_WIDTH(16),
        .C_SYNC_STAGES(2), .C_FILTER_LEN(3), .C_DIR_SETUP(4)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    step_pulse_decoder #(
        .C_STEP_NUMBER_WIDTH(16), .C_SPEED_DATA_WIDTH(4),
        .C_SYNC_STAGES(2), .C_FILTER_LEN(3), .C_DIR_SETUP(4)
    ) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    typedef struct {
        logic [15:0] pos;
        logic [15:0] cnt;
        bit          wrap;
        bit          err;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          ld;
        logic [15:0] ldv;
        bit          dir;
        logic [15:0] pos;
        logic [15:0] cnt;
        bit          wrap;
        bit          err;
    } vec_t;

    exp_t        exp_q[$];
    logic [15:0] per_q[$];
    vec_t        tbl[10];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          pv_cnt = 0;
    bit          mon_en = 1'b0;
    bit          model_running = 1'b0;
    int          last_rise = 0;
    logic [15:0] last_pos = '0;
    logic [15:0] last_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every position/step_count change pops one expectation,
    // every period_valid pulse pops one expected period.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.position !== last_pos || bus.step_count !== last_cnt) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_update", 32'(bus.position), 32'(last_pos));
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_position", 32'(bus.position), 32'(e.pos));
                    chk("sb_step_count", 32'(bus.step_count), 32'(e.cnt));
                    chk("sb_pos_wrap", 32'(bus.pos_wrap), 32'(e.wrap));
                    chk("sb_dir_err", 32'(bus.dir_err), 32'(e.err));
                end
            end
            if (bus.period_valid) begin
                pv_cnt <= pv_cnt + 1;
                if (per_q.size() == 0) chk("unexpected_period_valid", 32'(bus.period_valid), 32'd0);
                else                   chk("sb_rt_period", 32'(bus.rt_period), 32'(per_q.pop_front()));
            end
        end
        last_pos <= bus.position;
        last_cnt <= bus.step_count;
    end

    task automatic reset_seq(input bit dir);
        mon_en = 1'b0;
        reset = 1'b1;
        bus.i_drive = 1'b0;
        bus.i_dir = dir;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        model_running = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic do_load(input logic [15:0] val, input logic [15:0] cnt_now);
        exp_t e;
        e = '{val, cnt_now, 1'b0, 1'b0};
        exp_q.push_back(e);
        bus.pos_value = val;
        bus.pos_load = 1'b1;
        @(negedge clk);
        bus.pos_load = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Expected period is the spacing of drive rises in cycles (clk_en held high).
    task automatic drive_step(input bit dir, input int lead, input int hi, input int lo,
                              input logic [15:0] epos, input logic [15:0] ecnt,
                              input bit ewrap, input bit eerr,
                              input int clr_at, input int load_at, input logic [15:0] ld_val);
        exp_t e;
        bus.i_dir = dir;
        repeat (lead) @(negedge clk);
        e = '{epos, ecnt, ewrap, eerr};
        exp_q.push_back(e);
        if (model_running) per_q.push_back(16'(cyc - last_rise));
        last_rise = cyc;
        model_running = 1'b1;
        bus.i_drive = 1'b1;
        for (int i = 1; i <= hi + lo; i++) begin
            @(negedge clk);
            bus.err_clr   = (i == clr_at);
            bus.pos_load  = (i == load_at);
            bus.pos_value = ld_val;
            if (i == hi) bus.i_drive = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int   pv0, lat, n_upd, n_idle, pv4;
        exp_t e;

        tbl[0] = '{1'b1, 1'b0, 16'd0, 1'b0, 16'd1,      16'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 16'd0, 1'b0, 16'd2,      16'd2, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 16'd0, 1'b0, 16'd3,      16'd3, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'd0, 1'b0, 16'd4,      16'd4, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 16'd0, 1'b0, 16'd5,      16'd5, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 16'd2, 1'b1, 16'd1,      16'd1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd0,      16'd2, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 16'd0, 1'b1, 16'hFFFF,   16'd3, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 16'd0, 1'b1, 16'hFFFE,   16'd4, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 16'd0, 1'b1, 16'hFFFD,   16'd5, 1'b1, 1'b0};

        reset = 1'b1;
        bus.clk_en = 1'b1;  bus.i_drive = 1'b0;  bus.i_dir = 1'b0;
        bus.pos_load = 1'b0; bus.pos_value = '0;  bus.err_clr = 1'b0;
        bus4.clk_en = 1'b1; bus4.i_drive = 1'b0; bus4.i_dir = 1'b0;
        bus4.pos_load = 1'b0; bus4.pos_value = '0; bus4.err_clr = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_position", 32'(bus.position), 32'd0);
        chk("rst_step_count", 32'(bus.step_count), 32'd0);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_rt_period", 32'(bus.rt_period), 32'd0);
        chk("rst_period_valid", 32'(bus.period_valid), 32'd0);
        chk("rst_dir_err", 32'(bus.dir_err), 32'd0);
        chk("rst_pos_wrap", 32'(bus.pos_wrap), 32'd0);

        pv0 = 0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) reset_seq(tbl[i].dir);
            if (tbl[i].ld) do_load(tbl[i].ldv, 16'd0);
            if (i == 0) pv0 = pv_cnt;
            drive_step(tbl[i].dir, 0, 8, 8, tbl[i].pos, tbl[i].cnt, tbl[i].wrap, tbl[i].err,
                       -1, -1, 16'd0);
            if (i == 4) begin
                repeat (2) @(negedge clk);
                chk("fwd_state", 32'(bus.state), 32'd1);
                chk("fwd_rt_period", 32'(bus.rt_period), 32'd16);
                chk("fwd_period_count", 32'(pv_cnt - pv0), 32'd4);
                chk("fwd_dir_err", 32'(bus.dir_err), 32'd0);
            end
        end
        chk("bwd_pos_wrap", 32'(bus.pos_wrap), 32'd1);

        // Two-cycle glitch must be swallowed; three-cycle pulse steps once with 6-edge latency.
        reset_seq(1'b0);
        bus.i_drive = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_drive = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_position", 32'(bus.position), 32'd0);
        chk("glitch_step_count", 32'(bus.step_count), 32'd0);
        chk("glitch_state", 32'(bus.state), 32'd0);

        e = '{16'd1, 16'd1, 1'b0, 1'b0};
        exp_q.push_back(e);
        last_rise = cyc;
        model_running = 1'b1;
        lat = -1;
        bus.i_drive = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3) bus.i_drive = 1'b0;
            if (lat < 0 && bus.position == 16'd1) lat = i - 1;
        end
        chk("step_latency", 32'(lat), 32'd6);

        drive_step(1'b1, 2, 8, 8, 16'd0, 16'd2, 1'b0, 1'b1, -1, -1, 16'd0);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_clr_dir_err", 32'(bus.dir_err), 32'd0);

        drive_step(1'b0, 2, 8, 8, 16'd1, 16'd3, 1'b0, 1'b1, 6, -1, 16'd0);
        chk("set_wins_dir_err", 32'(bus.dir_err), 32'd1);

        pv0 = pv_cnt;
        drive_step(1'b0, 0, 8, 8, 16'd100, 16'd4, 1'b0, 1'b1, -1, 6, 16'd100);
        chk("load_step_position", 32'(bus.position), 32'd100);
        chk("load_step_period_count", 32'(pv_cnt - pv0), 32'd1);

        // Narrow period counter: two quick steps, then timeout back to IDLE.
        bus4.i_drive = 1'b1;
        repeat (4) @(negedge clk);
        bus4.i_drive = 1'b0;
        repeat (4) @(negedge clk);
        bus4.i_drive = 1'b1;
        repeat (4) @(negedge clk);
        bus4.i_drive = 1'b0;
        n_upd = -1; n_idle = -1; pv4 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus4.period_valid) pv4++;
            if (n_upd < 0 && bus4.step_count == 16'd2) n_upd = i;
            if (n_upd >= 0 && n_idle < 0 && bus4.state == 1'b0) n_idle = i;
        end
        chk("t4_update_seen", 32'(n_upd > 0), 32'd1);
        chk("t4_timeout_delay", 32'(n_idle - n_upd), 32'd15);
        chk("t4_rt_period", 32'(bus4.rt_period), 32'd8);
        chk("t4_period_count", 32'(pv4), 32'd1);

        bus4.i_drive = 1'b1;
        repeat (4) @(negedge clk);
        bus4.i_drive = 1'b0;
        pv4 = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus4.period_valid) pv4++;
        end
        chk("t4_restart_step_count", 32'(bus4.step_count), 32'd1);
        chk("t4_restart_state", 32'(bus4.state), 32'd1);
        chk("t4_restart_no_period", 32'(pv4), 32'd0);
        chk("t4_rt_period_held", 32'(bus4.rt_period), 32'd8);

        repeat (4) @(negedge clk);
        chk("sb_expect_left", 32'(exp_q.size()), 32'd0);
        chk("sb_period_left", 32'(per_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/step_pulse_decoder.md
Name: step_pulse_decoder

Overview:
Receive-side counterpart of the step-motor driver. It samples an external or looped-back drive/dir pair, filters glitches, and decodes step events into a signed-direction position. It also measures the step period in clk_en ticks and flags direction-setup violations. It sits beside a motor channel as a closed-loop monitor and feeds position, state and speed back to the register interface.

Parameters:
C_STEP_NUMBER_WIDTH, 16, width of position and step_count.
C_SPEED_DATA_WIDTH, 16, width of the period counter and rt_period.
C_SYNC_STAGES, 2, synchronizer flops on i_drive/i_dir (>=2).
C_FILTER_LEN, 3, consecutive clk cycles a synchronized level must differ before the filtered level flips (>=1).
C_DIR_SETUP, 4, minimum clk cycles filtered dir must be stable before a step event.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous reset, active-high.
clk_en  in  1  period-measurement tick; same tick as the driver's clk_en.
i_drive  in  1  step pulse, asynchronous.
i_dir  in  1  direction, asynchronous; 0 = forward (increment), 1 = backward (decrement).
pos_load  in  1  one-cycle pulse: position <= pos_value.
pos_value  in  C_STEP_NUMBER_WIDTH  preset value.
err_clr  in  1  one-cycle pulse; clears the sticky flags.
position  out  C_STEP_NUMBER_WIDTH  decoded position.
step_count  out  C_STEP_NUMBER_WIDTH  steps in the current move.
state  out  1  1 = RUNNING, 0 = IDLE.
rt_period  out  C_SPEED_DATA_WIDTH  last measured step period, in clk_en ticks.
period_valid  out  1  one-cycle pulse when rt_period updates.
dir_err  out  1  sticky direction-setup violation.
pos_wrap  out  1  sticky position wrap-around.

Behaviour:
- Reset values: all outputs 0, filtered levels 0, period counter 0, dir-stable counter 0, state IDLE.
- Input path:
  - C_SYNC_STAGES flops per input.
  - Per-signal filter counter counts cycles where synchronized != filtered.
  - Filtered level flips when the count reaches C_FILTER_LEN; the counter clears whenever synchronized == filtered.
- Step event: registered rising edge of filtered drive, i.e. filtered=1 and previous filtered=0.
- Latency: an i_drive rise captured at sampling edge 0 updates position/step_count at edge C_SYNC_STAGES+C_FILTER_LEN+1 (6 with defaults). The same latency applies to dir.
- Position on a step event:
  - filtered dir 0: +1, modulo 2^W; a wrap from max to 0 sets pos_wrap.
  - filtered dir 1: -1; a wrap from 0 to max sets pos_wrap.
- pos_load: has priority over a step event in the same cycle. The step is dropped from position but still counted in step_count and period logic.
- Dir-stable counter: clears on every filtered-dir change, otherwise increments, saturating at C_DIR_SETUP. A step event with counter < C_DIR_SETUP sets dir_err; the step still applies using the current filtered dir.
- Period counter: increments on clk_en and saturates at all-ones. It is set to 0 on a step event; a simultaneous clk_en is ignored in that cycle.
- State machine:
  - IDLE -> RUNNING on a step event. step_count <= 1 and period counter <= 0; no period_valid.
  - RUNNING, step event: rt_period <= period counter value before clear, period_valid=1 next cycle, step_count +1 (saturating).
  - RUNNING -> IDLE when the period counter reaches all-ones (timeout). rt_period holds its value; step_count holds until the next move.
- Sticky flags: cleared by err_clr. A set condition in the same cycle as err_clr wins (flag stays 1).
- Reset mid-move: all state returns to reset values next cycle. Any input already high is treated as a new level only after the filter re-qualifies it, so a held-high drive produces one step event after reset.
- Driver relation: driver half-period = speed_cur+1 ticks, so with continuous clk_en the measured rt_period = 2*(speed_cur+1).

Test Plan:
- Reset, then 5 clean pulses on i_drive (high 8 / low 8 cycles, clk_en=1, dir=0, stable) -> position=5, step_count=5, state=1, rt_period=16 reported 4 times, dir_err=0.
- Same pulses with dir=1, starting after pos_load value 2 -> position sequence 1,0,0xFFFF,0xFFFE,0xFFFD; pos_wrap=1 after the third step.
- 2-cycle glitch on i_drive with C_FILTER_LEN=3 -> no step event, position unchanged; a 3-cycle pulse -> exactly one step, first update 6 cycles after capture.
- dir toggled 2 filtered cycles before a step edge -> dir_err=1, step applied in the new dir; err_clr -> dir_err=0; err_clr coincident with a new violation -> dir_err stays 1.
- Stop pulsing with C_SPEED_DATA_WIDTH=4 and clk_en=1 -> state drops to 0 exactly 15 cycles after the last step event; the next step -> step_count=1 and no period_valid.
- pos_load asserted in the same cycle as a step event (value 100) -> position=100, step_count incremented, period_valid pulses.
